// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver with start/stop validation feeding a first-word-fall-through FIFO.
// Sticky frame_err/overrun flags report bad stop bits and bytes dropped on a full FIFO.
module uart_rx_unit #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEPTH        = 16,
   parameter int CNT_W        = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rxd,
   output logic [7:0]       uart_rx_data,
   output logic             empty,
   input  logic             uart_rd_en,
   output logic [CNT_W-1:0] count,
   output logic             frame_err,
   output logic             overrun,
   input  logic             clr_err
);

   localparam int AW     = $clog2(DEPTH);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic              sync1, rxs;
   logic [2:0]        state;
   logic [BAUD_W-1:0] baud;
   logic [2:0]        bit_idx;
   logic [7:0]        shift;
   logic              tick, push, set_fe;

   logic [7:0]        mem [DEPTH];
   logic [AW:0]       rd_ptr, wr_ptr;
   logic              full, pop, wr_en, drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
      end
   end

   // START waits half a bit so every later sample lands mid-bit
   assign tick   = (state == S_START) ? (baud == HALF_LAST) : (baud == FULL_LAST);
   assign push   = (state == S_STOP) && tick && rxs;
   assign set_fe = (state == S_STOP) && tick && !rxs;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               baud <= '0;
               if (!rxs) state <= S_START;
            end
            S_START: begin
               if (tick) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  state   <= rxs ? S_IDLE : S_DATA;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            S_DATA: begin
               if (tick) begin
                  baud           <= '0;
                  shift[bit_idx] <= rxs;
                  bit_idx        <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= S_STOP;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            S_STOP: begin
               if (tick) begin
                  baud  <= '0;
                  state <= rxs ? S_IDLE : S_BREAK;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            S_BREAK: begin
               // a held-low line must return high before a new frame can start
               if (rxs) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign empty = (rd_ptr == wr_ptr);
   assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
   assign pop   = uart_rd_en && !empty;
   // a pop in the same cycle frees the slot, so a full FIFO can still accept
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   assign uart_rx_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem[wr_ptr[AW-1:0]] <= shift;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (wr_en && !pop)      count <= count + CNT_W'(1);
         else if (pop && !wr_en) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= set_fe | (frame_err & ~clr_err);
         overrun   <= drop | (overrun & ~clr_err);
      end
   end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit: a queue-based model predicts FIFO/flag state every cycle,
// and literal checks pin the model at key points of each scenario.
module tb_uart_rx_unit;

   localparam int C     = 16;
   localparam int D     = 4;
   localparam int CNT_W = $clog2(D) + 1;
   // edges from rxd falling (driven mid-cycle) to the push edge: 2 sync flops,
   // one edge to leave IDLE, half a bit, then 9 full bits
   localparam int LAT   = 3 + C / 2 + 9 * C;

   logic             clk = 1'b0;
   logic             rst, rxd, uart_rd_en, clr_err;
   logic [7:0]       uart_rx_data;
   logic             empty, frame_err, overrun;
   logic [CNT_W-1:0] count;

   uart_rx_unit #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .rxd(rxd),
      .uart_rx_data(uart_rx_data), .empty(empty), .uart_rd_en(uart_rd_en),
      .count(count), .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [7:0] mq[$];
   bit         m_fe = 0, m_ov = 0;
   int         ev_cyc[$];
   logic [7:0] ev_byte[$];
   bit         ev_ok[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // model: frames become scheduled events; the FIFO is a plain queue
   always @(posedge clk) begin
      bit         push_ev, fe_ev, pop_m, drop;
      logic [7:0] b;
      cyc++;
      push_ev = 0; fe_ev = 0; b = '0;
      if (rst) begin
         mq.delete(); ev_cyc.delete(); ev_byte.delete(); ev_ok.delete();
         m_fe = 0; m_ov = 0;
      end else begin
         if (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
            b = ev_byte.pop_front();
            if (ev_ok.pop_front()) push_ev = 1; else fe_ev = 1;
            void'(ev_cyc.pop_front());
         end
         pop_m = uart_rd_en && mq.size() > 0;
         drop  = push_ev && mq.size() == D && !pop_m;
         m_fe  = fe_ev | (m_fe & !clr_err);
         m_ov  = drop | (m_ov & !clr_err);
         if (pop_m) void'(mq.pop_front());
         if (push_ev && !drop) mq.push_back(b);
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("empty", int'(empty), int'(mq.size() == 0));
         chk("count", int'(count), mq.size());
         if (mq.size() > 0) chk("data", int'(uart_rx_data), int'(mq[0]));
         chk("frame_err", int'(frame_err), int'(m_fe));
         chk("overrun", int'(overrun), int'(m_ov));
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input bit stop);
      ev_cyc.push_back(cyc + LAT);
      ev_byte.push_back(b);
      ev_ok.push_back(stop);
      rxd = 1'b0;
      idle(C);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         idle(C);
      end
      rxd = stop;
      idle(C);
   endtask

   task automatic pop_chk(input logic [7:0] exp);
      chk("lit_empty_before_rd", int'(empty), 0);
      chk("lit_rd_data", int'(uart_rx_data), int'(exp));
      uart_rd_en = 1'b1;
      @(negedge clk);
      uart_rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   initial begin
      int n0;
      logic [7:0] part;
      rst = 1'b1; rxd = 1'b1; uart_rd_en = 1'b0; clr_err = 1'b0;
      idle(3);
      chk("lit_rst_empty", int'(empty), 1);
      chk("lit_rst_count", int'(count), 0);
      chk("lit_rst_flags", int'({frame_err, overrun}), 0);
      rst = 1'b0;
      idle(10);

      // single byte, then one read
      send(8'h55, 1'b1);
      idle(4);
      chk("lit_55_data", int'(uart_rx_data), 'h55);
      chk("lit_55_count", int'(count), 1);
      pop_chk(8'h55);
      chk("lit_55_empty_after", int'(empty), 1);
      chk("lit_55_count_after", int'(count), 0);

      // back-to-back frames
      send(8'hA3, 1'b1);
      send(8'h0F, 1'b1);
      idle(4);
      chk("lit_b2b_count", int'(count), 2);
      pop_chk(8'hA3);
      pop_chk(8'h0F);
      chk("lit_b2b_ferr", int'(frame_err), 0);

      // short low glitch is not a start bit
      rxd = 1'b0; idle(4); rxd = 1'b1; idle(30);
      chk("lit_glitch_count", int'(count), 0);
      chk("lit_glitch_ferr", int'(frame_err), 0);
      send(8'h3C, 1'b1);
      idle(4);
      pop_chk(8'h3C);

      // bad stop bit followed by a held-low line
      send(8'h81, 1'b0);
      idle(40);
      rxd = 1'b1;
      idle(20);
      chk("lit_break_ferr", int'(frame_err), 1);
      chk("lit_break_count", int'(count), 0);
      send(8'h7E, 1'b1);
      idle(4);
      pop_chk(8'h7E);
      pulse_clr();
      chk("lit_clr_ferr", int'(frame_err), 0);

      // overflow without a read
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
      idle(4);
      chk("lit_ovr_count", int'(count), 4);
      chk("lit_ovr_flag", int'(overrun), 1);
      for (int i = 1; i <= 4; i++) pop_chk(8'(i));
      pulse_clr();
      chk("lit_ovr_clr", int'(overrun), 0);

      // overflow with a read landing on the 5th push edge
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
      n0 = cyc;
      fork
         send(8'h05, 1'b1);
         begin
            while (cyc != n0 + LAT - 1) @(negedge clk);
            uart_rd_en = 1'b1;
            @(negedge clk);
            uart_rd_en = 1'b0;
         end
      join
      idle(4);
      chk("lit_fullrw_count", int'(count), 4);
      chk("lit_fullrw_ovr", int'(overrun), 0);
      for (int i = 2; i <= 5; i++) pop_chk(8'(i));

      // reset mid-frame with bytes stored and a flag set
      send(8'h12, 1'b0);
      rxd = 1'b1;
      idle(20);
      send(8'hAA, 1'b1);
      send(8'hBB, 1'b1);
      idle(4);
      chk("lit_prerst_count", int'(count), 2);
      chk("lit_prerst_ferr", int'(frame_err), 1);
      part = 8'h5A;
      rxd = 1'b0; idle(C);
      for (int i = 0; i < 3; i++) begin
         rxd = part[i];
         idle(C);
      end
      rxd = part[3];
      idle(C / 2);
      rst = 1'b1; rxd = 1'b1;
      idle(2);
      chk("lit_mrst_empty", int'(empty), 1);
      chk("lit_mrst_count", int'(count), 0);
      chk("lit_mrst_flags", int'({frame_err, overrun}), 0);
      rst = 1'b0;
      idle(20);
      send(8'hC6, 1'b1);
      idle(4);
      chk("lit_C6_count", int'(count), 1);
      pop_chk(8'hC6);
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
